// File: rtl/score_keeper.sv
// score_keeper: game-flow FSM (IDLE/PLAY/OVER), saturating score, session high
// score and restart lockout. Every input is rising-edge detected; all outputs
// come from flops.
module score_keeper #(
  parameter int unsigned PTS_LARGE = 5,
  parameter int unsigned PTS_SMALL = 10,
  parameter int unsigned MAX_SCORE = 511,
  parameter int unsigned OVER_HOLD = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       hit_large,
  input  logic       hit_small,
  input  logic       ship_hit,
  output logic [1:0] state_set,
  output logic [8:0] score,
  output logic [8:0] high_score,
  output logic       new_high
);

  localparam int unsigned SW = 9;   // score width
  localparam int unsigned IW = 11;  // headroom width for the unclamped sum
  localparam int unsigned CW = 32;  // lockout counter width

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           start_q;
  logic           large_q;
  logic           small_q;
  logic           ship_q;
  logic           start_e;
  logic           large_e;
  logic           small_e;
  logic           ship_e;
  logic [CW-1:0]  hold_cnt;
  logic [IW-1:0]  incr;
  logic [IW-1:0]  sum;
  logic [SW-1:0]  score_nx;
  logic           score_clr;
  logic           score_upd;
  logic           game_end;

  // Previous-sample registers; set to 1 on reset so held inputs need a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      large_q <= 1'b1;
      small_q <= 1'b1;
      ship_q  <= 1'b1;
    end else begin
      start_q <= start_btn;
      large_q <= hit_large;
      small_q <= hit_small;
      ship_q  <= ship_hit;
    end
  end

  assign start_e = start_btn & ~start_q;
  assign large_e = hit_large & ~large_q;
  assign small_e = hit_small & ~small_q;
  assign ship_e  = ship_hit  & ~ship_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; restart from OVER waits for the lockout to expire.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_e) state_nx = PLAY;
      PLAY:    if (ship_e) state_nx = OVER;
      OVER:    if (start_e && (hold_cnt == '0)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-state control strobes for the score datapath and lockout counter.
  always_comb begin
    score_clr = 1'b0;
    score_upd = 1'b0;
    game_end  = 1'b0;
    case (state)
      IDLE:    score_clr = start_e;
      PLAY: begin
        score_upd = 1'b1;
        game_end  = ship_e;
      end
      default: ;
    endcase
  end

  // Saturating adder: widen, sum both hit values, clamp to the ceiling.
  always_comb begin
    incr     = (large_e ? IW'(PTS_LARGE) : IW'(0)) + (small_e ? IW'(PTS_SMALL) : IW'(0));
    sum      = IW'(score) + incr;
    score_nx = (sum > IW'(MAX_SCORE)) ? SW'(MAX_SCORE) : sum[SW-1:0];
  end

  // Score, high score and new-high flag; the clamped score of the ending clock is final.
  always_ff @(posedge clk) begin
    if (rst) begin
      score      <= '0;
      high_score <= '0;
      new_high   <= 1'b0;
    end else if (score_clr) begin
      score    <= '0;
      new_high <= 1'b0;
    end else if (score_upd) begin
      score <= score_nx;
      if (game_end && (score_nx > high_score)) begin
        high_score <= score_nx;
        new_high   <= 1'b1;
      end
    end
  end

  // Restart lockout: loaded on game end, counts down to zero while in OVER.
  always_ff @(posedge clk) begin
    if (rst)                                hold_cnt <= '0;
    else if (game_end)                      hold_cnt <= CW'(OVER_HOLD - 1);
    else if (state == OVER && hold_cnt != '0) hold_cnt <= hold_cnt - CW'(1);
  end

  assign state_set = state;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes expected outputs into a
// queue, a monitor on the falling edge pops and compares.
module tb_score_keeper;

  typedef struct packed {
    logic [1:0] st;
    logic [8:0] sc;
    logic [8:0] hs;
    logic       nh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       hit_large;
  logic       hit_small;
  logic       ship_hit;
  logic [1:0] state_set;
  logic [8:0] score;
  logic [8:0] high_score;
  logic       new_high;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clk = ~clk;

  score_keeper #(.OVER_HOLD(8)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .hit_large(hit_large),
    .hit_small(hit_small), .ship_hit(ship_hit), .state_set(state_set),
    .score(score), .high_score(high_score), .new_high(new_high)
  );

  // Monitor: compare one queued expectation per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (state_set !== e.st || score !== e.sc || high_score !== e.hs || new_high !== e.nh) begin
        n_miss++;
        $display("FAIL %s: got state=%b score=%0d high=%0d new_high=%b, expected state=%b score=%0d high=%0d new_high=%b",
                 nm, state_set, score, high_score, new_high, e.st, e.sc, e.hs, e.nh);
      end
    end
  end

  task automatic cyc(input logic s, input logic l, input logic sm, input logic sh);
    start_btn = s;
    hit_large = l;
    hit_small = sm;
    ship_hit  = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic [8:0] sc,
                     input logic [8:0] hs, input logic nh);
    exp_t e;
    e.st = st; e.sc = sc; e.hs = hs; e.nh = nh;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Sit out the lockout, return to IDLE, then start a fresh game.
  task automatic restart(input logic [8:0] sc, input logic [8:0] hs, input logic nh);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("over_to_idle", 2'b00, sc, hs, nh);
    cyc(0, 0, 0, 0); chk("idle_hold", 2'b00, sc, hs, nh);
    cyc(1, 0, 0, 0); chk("idle_to_play", 2'b01, 9'd0, hs, 1'b0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    int exp_sc;
    rst = 1'b1;
    start_btn = 1'b1; hit_large = 1'b1; hit_small = 1'b1; ship_hit = 1'b1;

    // Reset with all inputs held high, then keep them high.
    repeat (3) begin cyc(1, 1, 1, 1); chk("reset_held", 2'b00, 9'd0, 9'd0, 1'b0); end
    rst = 1'b0;
    repeat (10) begin cyc(1, 1, 1, 1); chk("held_no_edge", 2'b00, 9'd0, 9'd0, 1'b0); end
    cyc(0, 1, 1, 1); chk("start_dropped", 2'b00, 9'd0, 9'd0, 1'b0);
    cyc(1, 1, 1, 1); chk("start_edge", 2'b01, 9'd0, 9'd0, 1'b0);
    cyc(0, 0, 0, 0); chk("play_quiet", 2'b01, 9'd0, 9'd0, 1'b0);

    // Basic scoring.
    cyc(0, 1, 0, 0); chk("large", 2'b01, 9'd5, 9'd0, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("small", 2'b01, 9'd15, 9'd0, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0); chk("both", 2'b01, 9'd30, 9'd0, 1'b0);
    cyc(0, 0, 0, 0);
    repeat (50) begin cyc(0, 1, 0, 0); chk("large_held", 2'b01, 9'd35, 9'd0, 1'b0); end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("large_to_40", 2'b01, 9'd40, 9'd0, 1'b0);
    cyc(0, 0, 0, 0);

    // Game 1 ends at 40, then the lockout window.
    cyc(0, 0, 0, 1); chk("game1_over", 2'b10, 9'd40, 9'd40, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("lock_early", 2'b10, 9'd40, 9'd40, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("lock_late", 2'b10, 9'd40, 9'd40, 1'b1);
    cyc(0, 0, 0, 0); chk("lock_not_queued", 2'b10, 9'd40, 9'd40, 1'b1);
    cyc(1, 0, 0, 0); chk("lock_release", 2'b00, 9'd40, 9'd40, 1'b1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("restart", 2'b01, 9'd0, 9'd40, 1'b0);
    cyc(0, 0, 0, 0);

    // Game 2 ends at 40 via a large pulse train: tie, no new high.
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 0, 0); chk("pulse_train", 2'b01, 9'(5 * k), 9'd40, 1'b0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1); chk("game2_tie", 2'b10, 9'd40, 9'd40, 1'b0);
    restart(9'd40, 9'd40, 1'b0);

    // Game 3 ends at 25: high score unchanged.
    cyc(0, 0, 1, 0); chk("g3_small", 2'b01, 9'd10, 9'd40, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("g3_large", 2'b01, 9'd15, 9'd40, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("g3_small2", 2'b01, 9'd25, 9'd40, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("game3_lower", 2'b10, 9'd25, 9'd40, 1'b0);
    cyc(0, 1, 1, 0); chk("hit_in_over", 2'b10, 9'd25, 9'd40, 1'b0);
    cyc(0, 0, 0, 0);
    restart(9'd25, 9'd40, 1'b0);

    // Saturation: 52 small edges, then a large one.
    for (int k = 1; k <= 52; k++) begin
      exp_sc = (10 * k > 511) ? 511 : 10 * k;
      cyc(0, 0, 1, 0); chk("saturate", 2'b01, 9'(exp_sc), 9'd40, 1'b0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0); chk("sat_large", 2'b01, 9'd511, 9'd40, 1'b0);
    cyc(0, 0, 0, 0);

    // Reset in the middle of a game.
    rst = 1'b1;
    cyc(0, 0, 0, 0); chk("rst_mid", 2'b00, 9'd0, 9'd0, 1'b0);
    rst = 1'b0;
    cyc(0, 0, 0, 0); chk("after_rst", 2'b00, 9'd0, 9'd0, 1'b0);
    cyc(1, 0, 0, 0); chk("start_after_rst", 2'b01, 9'd0, 9'd0, 1'b0);
    cyc(0, 0, 0, 0);

    // Build high score 105.
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 1, 0); chk("to_100", 2'b01, 9'(10 * k), 9'd0, 1'b0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0); chk("to_105", 2'b01, 9'd105, 9'd0, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); chk("game_105", 2'b10, 9'd105, 9'd105, 1'b1);
    restart(9'd105, 9'd105, 1'b1);

    // Score 100, then a small edge together with ship_hit.
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 1, 0); chk("again_100", 2'b01, 9'(10 * k), 9'd105, 1'b0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 1, 1); chk("small_and_ship", 2'b10, 9'd110, 9'd110, 1'b1);
    cyc(0, 0, 0, 0); chk("over_hold", 2'b10, 9'd110, 9'd110, 1'b1);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-flow and scoring controller that sits directly upstream of the score display stage. It converts asteroid-hit and ship-hit event strobes from the collision logic into a saturating 9-bit score. It runs the title/play/game-over state machine and keeps a session high score. Its `score` and `state_set` outputs drive the score renderer's `score` and `state_set` inputs directly.

## Interface
Parameters:
- `PTS_LARGE`, default 5: points added per large-asteroid hit.
- `PTS_SMALL`, default 10: points added per small-asteroid hit.
- `MAX_SCORE`, default 511: saturation ceiling; must be ≤ 511.
- `OVER_HOLD`, default 200_000_000: clocks in game-over before restart is accepted (2 s at 100 MHz).

Ports:
- `clk`  in  1  100 MHz system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_btn`  in  1  debounced start button, level.
- `hit_large`  in  1  large-asteroid destroyed; level or pulse, may stay high for many clocks.
- `hit_small`  in  1  small-asteroid destroyed; level or pulse.
- `ship_hit`  in  1  ship collision; level or pulse.
- `state_set`  out  2  game state: 2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER. 2'b11 is never driven.
- `score`  out  9  current score, binary.
- `high_score`  out  9  best score this power-on session.
- `new_high`  out  1  high when the last completed game set a new high score.

## Operation
- All inputs are rising-edge detected against a registered previous sample (`*_q`).
  - An event fires on a clock where input = 1 and `*_q` = 0.
  - A level held high fires exactly once.
- Reset loads every `*_q` with 1, so an input held high through reset fires no event until it drops and rises again.
- State machine, one transition per clock at most:
  - IDLE → PLAY on a start edge. That same edge clears `score` to 0 and clears `new_high`.
  - PLAY → OVER on a ship_hit edge. That edge also loads the lockout counter with `OVER_HOLD`-1.
  - OVER → IDLE on a start edge, but only when the lockout counter = 0. Start edges while the counter is non-zero are discarded and are not queued.
  - The lockout counter decrements by 1 per clock in OVER until it reaches 0. It is 32 bits wide.
- Scoring happens only in PLAY. Hit edges in IDLE or OVER are ignored.
  - Increment = (large edge ? `PTS_LARGE` : 0) + (small edge ? `PTS_SMALL` : 0).
  - Simultaneous large and small edges add both values in one clock.
  - Next score = min(score + increment, `MAX_SCORE`). Compute in 11 bits and then clamp, so no wrap-around is possible.
- A hit edge in the same clock as a ship_hit edge is scored. The clamped next score is what becomes final.
- High-score update happens on the PLAY → OVER clock:
  - If the final score > `high_score`, then `high_score` ← final score and `new_high` ← 1.
  - If the final score equals `high_score`, there is no update and `new_high` stays 0.
- `score` holds its value through OVER and IDLE, so the final score is displayed. It clears only on the next IDLE → PLAY.
- Reset mid-game forces IDLE and zeroes `score`, `high_score`, `new_high` and the lockout counter.

## Timing
- Reset values:
  - `state_set` = 2'b00
  - `score` = 0
  - `high_score` = 0
  - `new_high` = 0
  - lockout counter = 0
  - all `*_q` = 1
- All outputs are registered, with no combinational path from input to output.
- Latency: an input rising at edge n (sampled 1 at n, 0 at n-1) shows its effect on the outputs after edge n. This applies to state change, score update, `high_score` and `new_high`.
- Back-to-back events: a pulse train alternating 1/0 each clock scores on every other clock with no lost events.
- The OVER → IDLE start edge is accepted earliest `OVER_HOLD` clocks after the PLAY → OVER edge.

## Test plan
- **Reset with inputs held:** hold `rst` 3 clocks with all inputs held high, release, keep inputs high 10 clocks.
  - Required: state stays 00 and `score` stays 0.
  - Then drop `start_btn` for 1 clock and raise it again. Required: state = 01 one clock later.
- **Scoring:** in PLAY, one large edge, then one small edge, then both in the same clock.
  - Required: `score` reads 5, then 15, then 30.
  - `hit_large` held high 50 clocks adds 5 only once.
- **Saturation:** in PLAY, 52 small edges.
  - Required: `score` = 510 after edge 51 and 511 after edge 52, never wrapping.
  - A further large edge keeps 511.
- **Game over and high score:** a game ending at score 40 with `high_score` = 0.
  - Required: state = 10, `high_score` = 40, `new_high` = 1.
  - A second game ending at 40: `high_score` = 40, `new_high` = 0.
  - A third game ending at 25: `high_score` stays 40.
- **Restart lockout** (`OVER_HOLD` = 8 for sim): start edge 3 clocks into OVER.
  - Required: ignored, state stays 10.
  - Start edge at clock 8 or later: state = 00 and `score` still holds the final value. The next start edge gives state 01 and `score` 0.
- **Simultaneous events and reset mid-game:** small edge and ship_hit edge in the same clock at score 100 with `high_score` 105.
  - Required: `score` = 110, state = 10, `high_score` = 110.
  - `rst` asserted mid-PLAY: all outputs return to reset values one clock later.
